usrt_tx: RTL and testbench
==========================

# usrt_tx

Transmit half of the USRT link. Accepts bytes over a valid/ready handshake, holds one byte in a holding register, and serialises each byte as an 11-bit frame on `o_Tx_Serial`. The frame is LSB-first: start, 8 data bits, parity/stop2, stop. The block generates the free-running bit clock `o_Bclk` from the system clock, which the far-end receiver uses to clock its shift register and to sample at the falling edge.

## Interface
- `CLKS_PER_BIT`, default 16: `i_Pclk` cycles per bit period. Must be even and ≥4; other values are unsupported.
- `i_Pclk`  in  1  system clock; all logic on its rising edge.
- `i_Rst`  in  1  synchronous, active-high reset.
- `i_Tx_Data`  in  8  byte to send; sampled on the accept cycle.
- `i_Tx_Valid`  in  1  byte offered.
- `o_Tx_Ready`  out  1  holding register empty; accept when `i_Tx_Valid & o_Tx_Ready`.
- `o_Tx_Serial`  out  1  serial line, registered; idle high.
- `o_Bclk`  out  1  bit clock, registered, 50% duty.
- `o_Busy`  out  1  high while a frame is on the line.
- `o_Done`  out  1  one-cycle pulse when a stop bit completes.

## Operation
- **Divider**
  - `r_Clk_Count` is a free-running counter, 0..CLKS_PER_BIT-1, then wraps.
  - The boundary tick is the cycle where `r_Clk_Count == CLKS_PER_BIT-1`.
  - `o_Bclk` is registered as (next count < CLKS_PER_BIT/2). It rises on the edge where the count becomes 0 and falls at count CLKS_PER_BIT/2, i.e. mid-bit.
- **Frame** (bit index 0..10):
  - bit 0 = 0 (start)
  - bits 1..8 = data[0..7]
  - bit 9 = parity or stop2 (see Configuration)
  - bit 10 = 1 (stop)
- **Holding register**
  - `o_Tx_Ready = ~r_Hold_Valid & ~i_Rst`.
  - Accept sets `r_Hold_Valid` and captures the data.
- **FSM**
  - IDLE: line is 1. On a boundary tick with `r_Hold_Valid`, load the frame from hold, clear hold, set bit index to 0, and go to SEND. The start bit appears on the following cycle.
  - SEND: on each boundary tick, advance the bit index and drive the next frame bit.
  - On the boundary tick ending bit 10:
    - pulse `o_Done`.
    - If hold is valid, load the next frame immediately (back-to-back, no idle bit) and stay in SEND.
    - Otherwise drive 1 and go to IDLE.
- `o_Busy` is high in SEND.
- The holding register may be refilled at any time during SEND. This gives one byte of buffering ahead of the shifter.
- **Accept on a boundary tick while IDLE:** the byte goes into hold only. It is loaded at the next boundary tick, so one full idle bit period precedes it.
- **Valid held with ready low:** no accept, no data loss; the source must hold the data stable.
- **Reset (any time, including mid-frame)**
  - Next cycle: `o_Tx_Serial=1`, `o_Bclk=1` (count=0), `o_Busy=0`, `o_Done=0`.
  - Hold is cleared; `o_Tx_Ready=0` during reset and 1 on the first cycle after.
  - Any partial frame is aborted.

## Timing
- Each frame bit is held for exactly CLKS_PER_BIT cycles. A frame lasts 11·CLKS_PER_BIT cycles.
- Accept-to-start-bit latency, from IDLE with hold empty: the start bit drives on the cycle after the first boundary tick strictly later than the accept cycle. That is 2..CLKS_PER_BIT+1 cycles.
- `o_Tx_Ready` rises on the cycle after the hold is loaded into the shifter.
- `o_Done` coincides with the cycle in which the line leaves the stop bit (or enters the next start bit).
- Back-to-back throughput is one byte per 11·CLKS_PER_BIT cycles.

## Configuration
- `USRT_TX_PARITY_EN`
  - Defined: bit 9 = even parity = XOR of the 8 data bits.
  - Undefined: bit 9 = 1, a second stop bit.
- Frame length is 11 bits in both builds.

## Test plan
- **Single byte with parity.** Set CLKS_PER_BIT=4 and `USRT_TX_PARITY_EN` defined, then send 0xA5. The line must carry 0,1,0,1,0,0,1,0,1,0,1, each bit for 4 cycles. `o_Done` pulses once and `o_Busy` is low afterwards.
- **Same stimulus without the macro.** Bit 9 must be 1. Then send 0x01: parity-enabled build gives bit 9 = 1; disabled build gives bit 9 = 1.
- **Back-to-back.** Send 0x00 and 0xFF with valid held high. The second start bit must follow the first stop bit with no idle bit. `o_Tx_Ready` drops after the second accept and rises after the second frame loads. `o_Done` pulses twice, 44 cycles apart.
- **Ready/valid stall.** With hold full, hold valid high for 30 cycles with changing data. Only the byte present on the accept cycle is transmitted.
- **Reset mid-frame.** Assert `i_Rst` at bit 4 of frame 0x3C. The next cycle must show line=1, Busy=0, Ready=0. After release, sending 0x55 produces a clean frame.
- **Loopback.** Drive the far-end receiver with `o_Bclk` and `o_Tx_Serial`. For 256 sequential bytes, received o_Data must equal {1, p, byte, 0}, where p is the parity or 1 per build.

Source files
------------

// File: rtl/usrt_tx.sv
// USRT transmitter: one-byte holding register feeding an 11-bit LSB-first frame shifter,
// plus a free-running bit clock. Define USRT_TX_PARITY_EN for even parity in bit 9.
module usrt_tx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       i_Pclk,
  input  logic       i_Rst,
  input  logic [7:0] i_Tx_Data,
  input  logic       i_Tx_Valid,
  output logic       o_Tx_Ready,
  output logic       o_Tx_Serial,
  output logic       o_Bclk,
  output logic       o_Busy,
  output logic       o_Done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2);

  typedef enum logic {StIdle, StSend} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] clk_count_q, clk_count_d;
  logic            bclk_q, bclk_d;
  logic            hold_valid_q, hold_valid_d;
  logic [7:0]      hold_data_q, hold_data_d;
  logic [10:0]     frame_q, frame_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic            serial_q, serial_d;
  logic            done_q, done_d;

  logic        tick;
  logic        accept;
  logic        load;
  logic        bit9;
  logic [3:0]  next_idx;
  logic [10:0] hold_frame;

  assign tick       = (clk_count_q == CntMax);
  assign o_Tx_Ready = ~hold_valid_q & ~i_Rst;
  assign accept     = i_Tx_Valid & o_Tx_Ready;
  assign next_idx   = bit_idx_q + 4'd1;

`ifdef USRT_TX_PARITY_EN
  assign bit9 = ^hold_data_q;
`else
  assign bit9 = 1'b1;
`endif

  assign hold_frame = {1'b1, bit9, hold_data_q, 1'b0};

  always_comb begin
    clk_count_d  = tick ? '0 : clk_count_q + 1'b1;
    // Bit clock rises as the count wraps to 0 and falls mid-bit.
    bclk_d       = (clk_count_d < CntHalf);
    state_d      = state_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    frame_d      = frame_q;
    bit_idx_d    = bit_idx_q;
    serial_d     = serial_q;
    done_d       = 1'b0;
    load         = 1'b0;

    case (state_q)
      StIdle: begin
        serial_d = 1'b1;
        if (tick && hold_valid_q) begin
          load    = 1'b1;
          state_d = StSend;
        end
      end
      StSend: begin
        if (tick) begin
          if (bit_idx_q == 4'd10) begin
            done_d = 1'b1;
            if (hold_valid_q) begin
              load = 1'b1;
            end else begin
              state_d  = StIdle;
              serial_d = 1'b1;
            end
          end else begin
            bit_idx_d = next_idx;
            serial_d  = frame_q[next_idx];
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      frame_d      = hold_frame;
      bit_idx_d    = 4'd0;
      serial_d     = 1'b0;
      hold_valid_d = 1'b0;
    end

    // Load and accept are exclusive: load needs a full hold, accept an empty one.
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_data_d  = i_Tx_Data;
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Rst) begin
      state_q      <= StIdle;
      clk_count_q  <= '0;
      bclk_q       <= 1'b1;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      frame_q      <= '1;
      bit_idx_q    <= '0;
      serial_q     <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_count_q  <= clk_count_d;
      bclk_q       <= bclk_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      frame_q      <= frame_d;
      bit_idx_q    <= bit_idx_d;
      serial_q     <= serial_d;
      done_q       <= done_d;
    end
  end

  assign o_Tx_Serial = serial_q;
  assign o_Bclk      = bclk_q;
  assign o_Busy      = (state_q == StSend);
  assign o_Done      = done_q;

endmodule

// File: tb/tb_usrt_tx.sv
// Directed bench for usrt_tx with CLKS_PER_BIT=4 and a far-end receiver model
// clocked by o_Bclk falling edges.
module tb_usrt_tx;

  localparam int unsigned Cpb = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_serial, bclk, busy, done;

  usrt_tx #(.CLKS_PER_BIT(Cpb)) dut (
    .i_Pclk     (clk),
    .i_Rst      (rst),
    .i_Tx_Data  (tx_data),
    .i_Tx_Valid (tx_valid),
    .o_Tx_Ready (tx_ready),
    .o_Tx_Serial(tx_serial),
    .o_Bclk     (bclk),
    .o_Busy     (busy),
    .o_Done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  // Far-end receiver: shifts the line in on each o_Bclk falling edge (mid-bit).
  logic [10:0] rx_q[$];
  logic [10:0] rx_sh = '1;
  int          rx_cnt = 0;
  always @(negedge bclk or posedge rst) begin
    if (rst) begin
      rx_cnt = 0;
    end else if (rx_cnt == 0) begin
      if (tx_serial == 1'b0) begin
        rx_sh  = {tx_serial, rx_sh[10:1]};
        rx_cnt = 1;
      end
    end else begin
      rx_sh  = {tx_serial, rx_sh[10:1]};
      rx_cnt = rx_cnt + 1;
      if (rx_cnt == 11) begin
        rx_q.push_back(rx_sh);
        rx_cnt = 0;
      end
    end
  end

  int   done_t[$];
  logic done_ser[$];
  logic done_rdy[$];
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_t.push_back(cyc);
      done_ser.push_back(tx_serial);
      done_rdy.push_back(tx_ready);
    end
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] frm(input logic [7:0] d, input logic p);
    logic b9;
    b9 = p;
`ifndef USRT_TX_PARITY_EN
    b9 = 1'b1;
`endif
    return {1'b1, b9, d, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] d, output int acc);
    logic ok;
    acc      = -1;
    tx_data  = d;
    tx_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      ok = tx_ready;
      step();
      if (ok) begin
        acc      = cyc - 1;
        tx_valid = 1'b0;
        return;
      end
    end
    tx_valid = 1'b0;
    check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_start(output int s);
    s = -1;
    for (int i = 0; i < 100; i++) begin
      if (tx_serial == 1'b0) begin
        s = cyc;
        return;
      end
      step();
    end
    check("start_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (rx_q.size() >= n) break;
      step();
    end
    check(name, rx_q.size(), n);
  endtask

  task automatic expect_frame(input logic [10:0] f, input string name, input int acc);
    int s;
    wait_start(s);
    if (s < 0) return;
    check({name, "_latency"}, ((s - acc) >= 2) && ((s - acc) <= int'(Cpb) + 1), 1);
    for (int b = 0; b < 11; b++) begin
      for (int c = 0; c < int'(Cpb); c++) begin
        check($sformatf("%s_bit%0d", name, b), {busy, tx_serial}, {1'b1, f[b]});
        step();
      end
    end
    check({name, "_done"}, {done, busy, tx_serial}, 3'b101);
    step();
    check({name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int acc;
    int s;
    logic [10:0] f;

    vecs[0] = '{data: 8'hA5, par: 1'b0};
    vecs[1] = '{data: 8'h01, par: 1'b1};
    vecs[2] = '{data: 8'h00, par: 1'b0};
    vecs[3] = '{data: 8'hFF, par: 1'b0};
    vecs[4] = '{data: 8'h3C, par: 1'b0};
    vecs[5] = '{data: 8'h80, par: 1'b1};
    vecs[6] = '{data: 8'h7F, par: 1'b1};
    vecs[7] = '{data: 8'h96, par: 1'b0};

    // Reset state and bit-clock phase.
    rst = 1'b1;
    step(3);
    check("rst_serial", tx_serial, 1);
    check("rst_bclk", bclk, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    for (int k = 1; k < 8; k++) begin
      step();
      if (k == 1) check("ready_after_rst", tx_ready, 1);
      check($sformatf("bclk_phase%0d", k), bclk, ((k % Cpb) < (Cpb / 2)) ? 1 : 0);
    end

    // Single frames from idle.
    for (int i = 0; i < 8; i++) begin
      send_byte(vecs[i].data, acc);
      expect_frame(frm(vecs[i].data, vecs[i].par), $sformatf("vec%0d", i), acc);
      check($sformatf("vec%0d_idle_busy", i), busy, 0);
      step(3);
    end

    // Back-to-back with valid held high.
    rx_q.delete();
    done_t.delete();
    done_ser.delete();
    done_rdy.delete();
    send_byte(8'h00, acc);
    send_byte(8'hFF, acc);
    check("b2b_ready_low", tx_ready, 0);
    wait_rx(2, 200, "b2b_rx_count");
    check("b2b_rx0", rx_q[0], frm(8'h00, 1'b0));
    check("b2b_rx1", rx_q[1], frm(8'hFF, 1'b0));
    for (int i = 0; i < 100; i++) begin
      if (done_t.size() >= 2) break;
      step();
    end
    check("b2b_done_count", done_t.size(), 2);
    check("b2b_done_gap", done_t[1] - done_t[0], 11 * Cpb);
    check("b2b_no_idle_bit", done_ser[0], 0);
    check("b2b_ready_at_load", done_rdy[0], 1);
    check("b2b_final_stop", done_ser[1], 1);
    step(5);

    // Ready/valid stall with the holding register full.
    rx_q.delete();
    send_byte(8'h11, acc);
    wait_start(s);
    send_byte(8'h22, acc);
    tx_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tx_data = 8'($urandom);
      check($sformatf("stall_ready%0d", i), tx_ready, 0);
      step();
    end
    tx_valid = 1'b0;
    wait_rx(2, 300, "stall_rx_count");
    check("stall_rx0", rx_q[0], frm(8'h11, 1'b0));
    check("stall_rx1", rx_q[1], frm(8'h22, 1'b0));
    step(22 * Cpb);
    check("stall_no_extra", rx_q.size(), 2);
    check("stall_idle", busy, 0);

    // Reset in the middle of frame 0x3C.
    send_byte(8'h3C, acc);
    wait_start(s);
    step(4 * Cpb);
    f = frm(8'h3C, 1'b0);
    check("mid_bit4", {busy, tx_serial}, {1'b1, f[4]});
    rst = 1'b1;
    step();
    check("midrst_serial", tx_serial, 1);
    check("midrst_busy", busy, 0);
    check("midrst_ready", tx_ready, 0);
    check("midrst_done", done, 0);
    check("midrst_bclk", bclk, 1);
    rst = 1'b0;
    step();
    check("midrst_ready_after", tx_ready, 1);
    rx_q.delete();
    send_byte(8'h55, acc);
    expect_frame(frm(8'h55, 1'b0), "post_rst", acc);
    check("post_rst_rx_count", rx_q.size(), 1);
    check("post_rst_rx", rx_q[0], frm(8'h55, 1'b0));

    // Loopback of all byte values through the receiver model.
    rx_q.delete();
    for (int i = 0; i < 256; i++) send_byte(8'(i), acc);
    wait_rx(256, 200, "loop_rx_count");
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      check($sformatf("loop_%02h", b), rx_q[i], frm(b, ^b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d)", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
